// File: rtl/exe_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package exe_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/exe_muldiv_if.sv
// Request/response bundle between the pipeline controller and the mul/div unit.
interface exe_muldiv_if #(parameter int XLEN = 32) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output in_valid, op, a, b, flush,
                  input  in_ready, busy, done, hi, lo);
  modport slave  (input  in_valid, op, a, b, flush,
                  output in_ready, busy, done, hi, lo);
endinterface

// File: rtl/exe_muldiv_iter.sv
// Bit-serial datapath: shift-add multiply or restoring divide on magnitudes,
// one step per enabled edge. acc/mq end up as {hi,lo} product or {rem,quo}.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step_mul,
  input  logic            step_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] mq
);

  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opnd};
    shifted = {acc, mq[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mq   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      mq   <= a_mag;
      opnd <= b_mag;
    end else if (step_mul) begin
      // Add multiplicand when the outgoing multiplier bit is set, then shift right.
      if (mq[0]) begin
        acc <= sum[XLEN:1];
        mq  <= {sum[0], mq[XLEN-1:1]};
      end else begin
        acc <= {1'b0, acc[XLEN-1:1]};
        mq  <= {acc[0], mq[XLEN-1:1]};
      end
    end else if (step_div) begin
      // A zero divisor always "fits": quotient becomes all ones, remainder the dividend.
      if (!diff[XLEN]) begin
        acc <= diff[XLEN-1:0];
        mq  <= {mq[XLEN-2:0], 1'b1};
      end else begin
        acc <= shifted[XLEN-1:0];
        mq  <= {mq[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
module exe_muldiv
  import exe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  exe_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              md_div, neg_res, neg_rem, div_zero, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [XLEN-1:0]   acc, mq;

  logic              in_ready, accept, is_md, is_div, is_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    in_ready  = (state == ST_IDLE);
    accept    = bus.in_valid & in_ready & ~bus.flush;
    is_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = is_signed & bus.a[XLEN-1];
    b_neg     = is_signed & bus.b[XLEN-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    prod      = {acc, mq};
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = div_zero ? '1 : (neg_res ? -mq : mq);
    rem_fix   = neg_rem ? -acc : acc;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept & is_md),
    .step_mul (state == ST_MUL),
    .step_div (state == ST_DIV),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (acc),
    .mq       (mq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      md_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (bus.op == OP_MTHI) hi_q <= bus.a;
          if (bus.op == OP_MTLO) lo_q <= bus.a;
          if (is_md) begin
            md_div   <= is_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= is_div && (bus.b == '0);
            cnt      <= '0;
            state    <= is_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL, ST_DIV: begin
          if (bus.flush) state <= ST_IDLE;
          else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) state <= ST_FIN;
          end
        end
        default: begin
          state <= ST_IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (md_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*XLEN-1:XLEN];
              lo_q <= prod_fix[XLEN-1:0];
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = ~in_ready;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
